tdc_clk_ctrl: RTL and testbench
===============================

TDC_CLK_CTRL -- requirements
Module: tdc_clk_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_PERIODS, default 2, giving the number of full clk_TDC periods waited after a ratio change before completion is reported (range 1..15).
REQ-002 SHALL have parameter RATIO_RST, default 8'd4, giving the divider ratio active after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on posedge clk.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: run request for the TDC clock.
REQ-006 SHALL have port ratio_req, input, 8 bits: requested ratio; half-period is ratio+1 clk cycles.
REQ-007 SHALL have port req_valid, input, 1 bit: ratio_req is valid.
REQ-008 SHALL have port req_ready, output, 1 bit: a new request can be accepted.
REQ-009 SHALL have port ratio_act, output, 8 bits: ratio currently driving the divider.
REQ-010 SHALL have port clk_TDC, output, 1 bit: registered divided clock.
REQ-011 SHALL have port running, output, 1 bit: the divider is toggling.
REQ-012 SHALL have port upd_done, output, 1 bit: one-cycle pulse when an accepted request has completed.

Function
REQ-013 SHALL implement states OFF, RUN, PEND (new ratio waiting for boundary) and SETTLE (counting periods after apply).
REQ-014 SHALL define a boundary as the cycle with cnt==ratio_act and clk_TDC==1, i.e. the cycle before a falling edge.
REQ-015 SHALL, in RUN/PEND/SETTLE, increment 8-bit cnt each cycle; at cnt==ratio_act, cnt<=0 and clk_TDC toggles, giving period 2*(ratio_act+1) clk cycles for any ratio 0..255 (0xFF is an ordinary ratio; no bypass).
REQ-016 SHALL assert req_ready only in OFF and RUN; a request is accepted on req_valid&&req_ready and ratio_req is captured into ratio_pend.
REQ-017 SHALL, when a request is accepted in RUN, go to PEND; at the next boundary ratio_act<=ratio_pend, cnt<=0, clk_TDC<=0, then go to SETTLE.
REQ-018 SHALL count clk_TDC rising edges in SETTLE; on the SETTLE_PERIODS-th edge, pulse upd_done for one cycle and go to RUN.
REQ-019 SHALL, when a request is accepted in OFF, load ratio_act on the next cycle, pulse upd_done in that same cycle, and stay in OFF.
REQ-020 SHALL, on en going low in RUN, stop at the next boundary with clk_TDC=0, cnt=0, and go to OFF.
REQ-021 SHALL, on en going high in OFF, start with cnt=0, clk_TDC=0 and enter RUN; the first rising edge occurs ratio_act+1 cycles later.
REQ-022 SHALL, when en goes low during PEND, apply the ratio at the boundary, pulse upd_done at the same boundary, and enter OFF without settling.
REQ-023 SHALL, when en goes low during SETTLE, abort settling at the next boundary, pulse upd_done there, and enter OFF.
REQ-024 SHALL never produce a clk_TDC high or low phase shorter than min(old,new) ratio+1 cycles: no runt pulses.
REQ-025 SHALL drive running high exactly in RUN, PEND and SETTLE.

Reset
REQ-026 SHALL, while rst_n is low, set state=OFF, cnt=0, clk_TDC=0, ratio_act=RATIO_RST, ratio_pend=RATIO_RST, settle count=0, upd_done=0, running=0 and req_ready=1.
REQ-027 SHALL abandon any pending or settling request on reset assertion mid-operation, with no upd_done.

Structure
REQ-028 SHALL place the state encodings and RATIO_RST default in the shared TDC constants package.
REQ-029 SHALL use one sub-module, tdc_div_core (cnt, toggle, boundary flag, load/stop controls), with the FSM in the top level.

Verification
REQ-030 SHALL verify: reset, en=1, ratio_act=4 -> clk_TDC period of 10 clk cycles, first rise 5 cycles after RUN entry.
REQ-031 SHALL verify: in RUN at ratio 4, request 8'd1 accepted mid-high-phase -> the high phase completes at 5 cycles, the next low phase is 2 cycles, the period is 4, and upd_done pulses on the 2nd rising edge after apply.
REQ-032 SHALL verify: en=0 with request 8'd200 -> upd_done on the next cycle, then en=1 gives a period of 402 cycles.
REQ-033 SHALL verify: a request followed by en dropping in PEND -> a single upd_done at the boundary, clk_TDC held at 0, and running=0.
REQ-034 SHALL verify: req_valid held high during PEND/SETTLE -> req_ready=0 with no capture, accepted only after upd_done.
REQ-035 SHALL verify: rst_n asserted during SETTLE -> all outputs take their reset values asynchronously and no upd_done is produced.

Source files
------------

// File: rtl/tdc_clk_ctrl_pkg.sv
// Shared TDC clock-control constants: FSM state encodings and reset ratio.
package tdc_clk_ctrl_pkg;

   localparam logic [1:0] ST_OFF    = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PEND   = 2'd2;
   localparam logic [1:0] ST_SETTLE = 2'd3;

   localparam logic [7:0] TDC_RATIO_RST = 8'd4;

   // Divider is toggling in every state except OFF.
   function automatic logic st_running(input logic [1:0] st);
      return st != ST_OFF;
   endfunction

   // New ratio requests are only taken when nothing is in flight.
   function automatic logic st_ready(input logic [1:0] st);
      return (st == ST_OFF) || (st == ST_RUN);
   endfunction

endpackage

// File: rtl/tdc_div_core.sv
// Divider core: half-period counter, registered toggle output and phase flags.
module tdc_div_core (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       load,
   input  logic [7:0] ratio,
   output logic       clk_div,
   output logic       boundary,
   output logic       rise
);

   logic [7:0] cnt_q;
   logic       div_q;
   logic       at_max;

   assign at_max   = (cnt_q == ratio);
   // Last cycle of a high phase: the next edge is a falling edge.
   assign boundary = run && at_max && div_q;
   // Last cycle of a low phase: the next edge is a rising edge.
   assign rise     = run && at_max && !div_q;
   assign clk_div  = div_q;

   // Counter and toggle; load forces a clean low phase starting from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
         div_q <= 1'b0;
      end else if (load) begin
         cnt_q <= 8'd0;
         div_q <= 1'b0;
      end else if (run) begin
         if (at_max) begin
            cnt_q <= 8'd0;
            div_q <= ~div_q;
         end else begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

endmodule

// File: rtl/tdc_clk_ctrl.sv
// TDC clock controller: glitch-free ratio changes applied on falling-edge
// boundaries, followed by a settle window before completion is reported.
module tdc_clk_ctrl
   import tdc_clk_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_PERIODS = 2,
   parameter logic [7:0]  RATIO_RST      = TDC_RATIO_RST
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] ratio_req,
   input  logic       req_valid,
   output logic       req_ready,
   output logic [7:0] ratio_act,
   output logic       clk_TDC,
   output logic       running,
   output logic       upd_done
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_PERIODS - 1);

   logic [1:0] state_q, state_d;
   logic [7:0] ratio_act_q, ratio_act_d;
   logic [7:0] ratio_pend_q, ratio_pend_d;
   logic [3:0] settle_q, settle_d;
   logic       upd_done_q, upd_done_d;
   logic       core_run, core_load;
   logic       boundary, rise;
   logic       accept;

   assign req_ready = st_ready(state_q);
   assign running   = st_running(state_q);
   assign accept    = req_valid && req_ready;
   assign ratio_act = ratio_act_q;
   assign upd_done  = upd_done_q;

   tdc_div_core u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (core_run),
      .load     (core_load),
      .ratio    (ratio_act_q),
      .clk_div  (clk_TDC),
      .boundary (boundary),
      .rise     (rise)
   );

   // Next-state logic; all ratio switches and stops happen on a boundary so
   // the output only ever changes 1->0 where it would anyway.
   always_comb begin
      state_d      = state_q;
      ratio_act_d  = ratio_act_q;
      ratio_pend_d = ratio_pend_q;
      settle_d     = settle_q;
      upd_done_d   = 1'b0;
      core_run     = st_running(state_q);
      core_load    = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (accept) begin
               ratio_pend_d = ratio_req;
               ratio_act_d  = ratio_req;
               upd_done_d   = 1'b1;
            end
            if (en) begin
               core_load = 1'b1;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!en && boundary) begin
               core_load = 1'b1;
               state_d   = ST_OFF;
               // Divider stops here, so a same-cycle request completes at once.
               if (accept) begin
                  ratio_pend_d = ratio_req;
                  ratio_act_d  = ratio_req;
                  upd_done_d   = 1'b1;
               end
            end else if (accept) begin
               ratio_pend_d = ratio_req;
               state_d      = ST_PEND;
            end
         end
         ST_PEND: begin
            if (boundary) begin
               ratio_act_d = ratio_pend_q;
               core_load   = 1'b1;
               if (en) begin
                  settle_d = 4'd0;
                  state_d  = ST_SETTLE;
               end else begin
                  upd_done_d = 1'b1;
                  state_d    = ST_OFF;
               end
            end
         end
         ST_SETTLE: begin
            if (!en && boundary) begin
               core_load  = 1'b1;
               upd_done_d = 1'b1;
               settle_d   = 4'd0;
               state_d    = ST_OFF;
            end else if (rise) begin
               // upd_done is registered with the same edge that raises clk_TDC.
               if (settle_q == SETTLE_LAST) begin
                  upd_done_d = 1'b1;
                  settle_d   = 4'd0;
                  state_d    = ST_RUN;
               end else begin
                  settle_d = settle_q + 4'd1;
               end
            end
         end
         default: state_d = ST_OFF;
      endcase
   end

   // State registers; reset abandons any request in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_OFF;
         ratio_act_q  <= RATIO_RST;
         ratio_pend_q <= RATIO_RST;
         settle_q     <= 4'd0;
         upd_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ratio_act_q  <= ratio_act_d;
         ratio_pend_q <= ratio_pend_d;
         settle_q     <= settle_d;
         upd_done_q   <= upd_done_d;
      end
   end

endmodule

// File: tb/tb_tdc_clk_ctrl.sv
// Directed bench for tdc_clk_ctrl: start-up timing, ratio changes, stop paths,
// request handshake and asynchronous reset mid-settle.
module tb_tdc_clk_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] ratio_req;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] ratio_act;
   logic       clk_TDC;
   logic       running;
   logic       upd_done;

   int tests = 0;
   int fails = 0;
   int upd_cnt = 0;

   tdc_clk_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .ratio_req (ratio_req),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .ratio_act (ratio_act),
      .clk_TDC   (clk_TDC),
      .running   (running),
      .upd_done  (upd_done)
   );

   always #5 clk = ~clk;

   // One clock, sampled 1ns after the edge; tallies upd_done pulses seen.
   task automatic tick();
      @(posedge clk);
      #1;
      if (upd_done === 1'b1) upd_cnt++;
   endtask

   // Ticks until clk_TDC reaches lvl; n = ticks taken, -1 on timeout.
   task automatic wait_level(input logic lvl, input int budget, output int n);
      n = 0;
      while (clk_TDC !== lvl && n < budget) begin
         tick();
         n++;
      end
      if (clk_TDC !== lvl) n = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; req_valid = 1'b0; ratio_req = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (clk_TDC !== 1'b0) begin fails++; $display("FAIL rst_clk_tdc: got %b expected 0", clk_TDC); end
      tests++; if (running !== 1'b0) begin fails++; $display("FAIL rst_running: got %b expected 0", running); end
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
      tests++; if (ratio_act !== 8'd4) begin fails++; $display("FAIL rst_ratio_act: got %0d expected 4", ratio_act); end
      tests++; if (upd_done !== 1'b0) begin fails++; $display("FAIL rst_upd_done: got %b expected 0", upd_done); end
      rst_n = 1'b1;
      repeat (2) tick();
      tests++; if (running !== 1'b0 || clk_TDC !== 1'b0) begin fails++; $display("FAIL idle_off: got running=%b clk=%b expected 0 0", running, clk_TDC); end
   endtask

   task automatic test_start();
      int first, hi, lo;
      en = 1'b1;
      tick();
      tests++; if (running !== 1'b1 || clk_TDC !== 1'b0) begin fails++; $display("FAIL start_entry: got running=%b clk=%b expected 1 0", running, clk_TDC); end
      wait_level(1'b1, 50, first);
      wait_level(1'b0, 50, hi);
      wait_level(1'b1, 50, lo);
      tests++; if (first != 5) begin fails++; $display("FAIL start_first_rise: got %0d expected 5", first); end
      tests++; if (hi + lo != 10 || hi != 5) begin fails++; $display("FAIL start_period: got hi=%0d lo=%0d expected 5 5", hi, lo); end
   endtask

   task automatic test_ratio_change();
      int n, lo, hi2, lo2, base;
      // clk_TDC has just risen; move two cycles into the high phase.
      repeat (2) tick();
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL chg_ready_run: got %b expected 1", req_ready); end
      req_valid = 1'b1; ratio_req = 8'd1;
      tick();
      req_valid = 1'b0;
      tests++; if (req_ready !== 1'b0 || running !== 1'b1) begin fails++; $display("FAIL chg_pend: got ready=%b running=%b expected 0 1", req_ready, running); end
      base = upd_cnt;
      wait_level(1'b0, 50, n);
      tests++; if (n < 0 || n + 3 != 5) begin fails++; $display("FAIL chg_old_high: got %0d expected 5", n + 3); end
      tests++; if (ratio_act !== 8'd1) begin fails++; $display("FAIL chg_applied: got %0d expected 1", ratio_act); end
      wait_level(1'b1, 50, lo);
      tests++; if (lo != 2 || upd_done !== 1'b0) begin fails++; $display("FAIL chg_new_low: got lo=%0d upd=%b expected 2 0", lo, upd_done); end
      wait_level(1'b0, 50, hi2);
      wait_level(1'b1, 50, lo2);
      tests++; if (hi2 + lo2 != 4) begin fails++; $display("FAIL chg_new_period: got %0d expected 4", hi2 + lo2); end
      tests++; if (upd_done !== 1'b1 || upd_cnt - base != 1) begin fails++; $display("FAIL chg_upd_2nd_rise: got upd=%b count=%0d expected 1 1", upd_done, upd_cnt - base); end
      tick();
      tests++; if (upd_done !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL chg_back_run: got upd=%b ready=%b expected 0 1", upd_done, req_ready); end
   endtask

   task automatic test_off_request();
      int n, first, hi, lo;
      en = 1'b0;
      n = 0;
      while (running !== 1'b0 && n < 20) begin tick(); n++; end
      tests++; if (running !== 1'b0 || clk_TDC !== 1'b0) begin fails++; $display("FAIL stop_run: got running=%b clk=%b expected 0 0", running, clk_TDC); end
      req_valid = 1'b1; ratio_req = 8'd200;
      tick();
      req_valid = 1'b0;
      tests++; if (upd_done !== 1'b1 || ratio_act !== 8'd200) begin fails++; $display("FAIL off_req: got upd=%b ratio=%0d expected 1 200", upd_done, ratio_act); end
      tick();
      tests++; if (upd_done !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL off_req_pulse: got upd=%b running=%b expected 0 0", upd_done, running); end
      en = 1'b1;
      tick();
      wait_level(1'b1, 300, first);
      wait_level(1'b0, 300, hi);
      wait_level(1'b1, 300, lo);
      tests++; if (first != 201) begin fails++; $display("FAIL r200_first_rise: got %0d expected 201", first); end
      tests++; if (hi + lo != 402 || hi != 201) begin fails++; $display("FAIL r200_period: got hi=%0d lo=%0d expected 201 201", hi, lo); end
   endtask

   task automatic test_pend_drop();
      int n, base;
      req_valid = 1'b1; ratio_req = 8'd3;
      tick();
      req_valid = 1'b0;
      en = 1'b0;
      base = upd_cnt;
      n = 0;
      while (running !== 1'b0 && n < 600) begin tick(); n++; end
      tests++; if (running !== 1'b0 || upd_done !== 1'b1) begin fails++; $display("FAIL pend_drop_stop: got running=%b upd=%b expected 0 1", running, upd_done); end
      tests++; if (clk_TDC !== 1'b0 || ratio_act !== 8'd3) begin fails++; $display("FAIL pend_drop_state: got clk=%b ratio=%0d expected 0 3", clk_TDC, ratio_act); end
      repeat (5) tick();
      tests++; if (upd_cnt - base != 1 || clk_TDC !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL pend_drop_hold: got pulses=%0d clk=%b running=%b expected 1 0 0", upd_cnt - base, clk_TDC, running); end
   endtask

   task automatic test_back_to_back();
      int bad, got;
      en = 1'b1;
      tick();
      req_valid = 1'b1; ratio_req = 8'd2;
      tick();
      ratio_req = 8'd7;
      bad = 0; got = 0;
      for (int i = 0; i < 200; i++) begin
         if (upd_done === 1'b1) begin got = 1; break; end
         if (req_ready !== 1'b0) bad++;
         tick();
      end
      tests++; if (got != 1 || bad != 0) begin fails++; $display("FAIL hold_ready_low: got done=%0d ready_high_cycles=%0d expected 1 0", got, bad); end
      tests++; if (ratio_act !== 8'd2 || req_ready !== 1'b1) begin fails++; $display("FAIL hold_no_capture: got ratio=%0d ready=%b expected 2 1", ratio_act, req_ready); end
      tick();
      req_valid = 1'b0;
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL hold_accept_after: got ready=%b expected 0", req_ready); end
      got = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (upd_done === 1'b1) begin got = 1; break; end
      end
      tests++; if (got != 1 || ratio_act !== 8'd7) begin fails++; $display("FAIL hold_second_req: got done=%0d ratio=%0d expected 1 7", got, ratio_act); end
   endtask

   task automatic test_reset_settle();
      int n, base;
      req_valid = 1'b1; ratio_req = 8'd0;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (ratio_act !== 8'd0 && n < 50) begin tick(); n++; end
      tests++; if (ratio_act !== 8'd0 || running !== 1'b1) begin fails++; $display("FAIL rs_applied: got ratio=%0d running=%b expected 0 1", ratio_act, running); end
      base = upd_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (running !== 1'b0 || clk_TDC !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL rs_async_ctrl: got running=%b clk=%b ready=%b expected 0 0 1", running, clk_TDC, req_ready); end
      tests++; if (ratio_act !== 8'd4 || upd_done !== 1'b0) begin fails++; $display("FAIL rs_async_ratio: got ratio=%0d upd=%b expected 4 0", ratio_act, upd_done); end
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (8) tick();
      tests++; if (upd_cnt != base) begin fails++; $display("FAIL rs_no_upd: got %0d pulses expected 0", upd_cnt - base); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_ratio_change();
      test_off_request();
      test_pend_drop();
      test_back_to_back();
      test_reset_settle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
